mem_lsu: RTL and testbench

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_lsu_pkg.sv | 40 ++++
 rtl/mem_lsu_align.sv | 47 ++++
 rtl/mem_lsu.sv | 239 +++++++++++++++++++++++
 tb/tb_mem_lsu.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared core definitions for the MEM-stage load/store unit.
// Opcode and funct3 encodings, access sizes, LSU FSM states.
// Pure declarations; no logic, no latency, no flow control.
package mem_lsu_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_HOLD   = 2'd2
  } lsu_state_e;

  // Low-address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(input logic [1:0] sz);
    case (sz)
      SZ_B:    align_mask = 3'b000;
      SZ_H:    align_mask = 3'b001;
      SZ_W:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Byte-lane alignment: store data/enables shifted to the lane, load lane extracted and extended.
// Purely combinational, zero latency.
// No flow control; outputs follow inputs.
module lsu_align
  import mem_lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [$clog2(XLEN/8)-1:0] off_i,
  input  logic [1:0]                size_i,
  input  logic                      uns_i,
  input  logic [XLEN-1:0]           sdata_i,
  input  logic [XLEN-1:0]           rdata_i,
  output logic [XLEN/8-1:0]         be_o,
  output logic [XLEN-1:0]           wdata_o,
  output logic [XLEN-1:0]           ldata_o
);

  logic [XLEN/8-1:0] lane_mask;
  logic [XLEN-1:0]   shifted;

  // Store side: size mask and data moved up to the addressed byte lane.
  always_comb begin
    lane_mask = '0;
    case (size_i)
      SZ_B:    lane_mask = (XLEN/8)'(1);
      SZ_H:    lane_mask = (XLEN/8)'(3);
      SZ_W:    lane_mask = (XLEN/8)'(15);
      default: lane_mask = '1;
    endcase
    be_o    = lane_mask << off_i;
    wdata_o = sdata_i << {off_i, 3'b000};
  end

  // Load side: bring the addressed lane down to bit 0, then sign/zero extend.
  always_comb begin
    shifted = rdata_i >> {off_i, 3'b000};
    ldata_o = shifted;
    case (size_i)
      SZ_B:    ldata_o = uns_i ? XLEN'(shifted[7:0])  : XLEN'($signed(shifted[7:0]));
      SZ_H:    ldata_o = uns_i ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
      SZ_W:    ldata_o = uns_i ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
      default: ldata_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM stage: data-memory access FSM, branch resolution and writeback pipeline registers.
// Zero added latency when DMEM_ACK arrives with the request; otherwise stalls until ACK or timeout.
// MEM_STALL holds upstream while a request is outstanding; WB_STALL freezes WB regs (read data parked in HOLD).
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              WB_STALL,
  input  logic              MEM_V,
  input  logic [31:0]       MEM_IR,
  input  logic [XLEN-1:0]   MEM_ALU_RESULT,
  input  logic [XLEN-1:0]   MEM_SR1,
  input  logic [XLEN-1:0]   MEM_SR2,
  input  logic [XLEN-1:0]   MEM_NPC,
  output logic              DMEM_REQ,
  output logic              DMEM_WE,
  output logic [XLEN-1:0]   DMEM_ADDR,
  output logic [XLEN/8-1:0] DMEM_BE,
  output logic [XLEN-1:0]   DMEM_WDATA,
  input  logic              DMEM_ACK,
  input  logic [XLEN-1:0]   DMEM_RDATA,
  output logic              WB_V,
  output logic [31:0]       WB_IR,
  output logic [XLEN-1:0]   WB_NPC,
  output logic [XLEN-1:0]   WB_ALU_RESULT,
  output logic [XLEN-1:0]   WB_MEM_RESULT,
  output logic              WB_PC_MUX,
  output logic              MEM_LAM,
  output logic              MEM_SAM,
  output logic              MEM_LAF,
  output logic              MEM_SAF,
  output logic              MEM_STALL
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT + 1);

  lsu_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   hold_q, hold_d;

  logic [6:0]        opcode;
  logic [2:0]        f3;
  logic [1:0]        size;
  logic [OW-1:0]     off;
  logic [2:0]        amask;
  logic              is_load, is_store, misal, bad_size, mem_ok;
  logic              req, stall, tmo, adv;
  logic              pc_mux;
  logic [NB-1:0]     be;
  logic [XLEN-1:0]   wdata, ldata, mem_res;

  logic              wb_v_q, wb_pc_mux_q;
  logic [31:0]       wb_ir_q;
  logic [XLEN-1:0]   wb_npc_q, wb_alu_q, wb_mem_q;
  logic              lam_q, sam_q, laf_q, saf_q;

  assign opcode   = MEM_IR[6:0];
  assign f3       = MEM_IR[14:12];
  assign size     = f3[1:0];
  assign off      = MEM_ALU_RESULT[OW-1:0];
  assign amask    = align_mask(size);
  assign is_load  = MEM_V && (opcode == OPC_LOAD);
  assign is_store = MEM_V && (opcode == OPC_STORE);
  assign misal    = |(off & amask[OW-1:0]);
  // Doubleword accesses do not exist on a 32-bit datapath: fault instead of issuing.
  assign bad_size = (XLEN == 32) && (size == SZ_D);
  assign mem_ok   = (is_load || is_store) && !misal && !bad_size;

  lsu_align #(.XLEN(XLEN)) u_align (
    .off_i   (off),
    .size_i  (size),
    .uns_i   (f3[2]),
    .sdata_i (MEM_SR2),
    .rdata_i (DMEM_RDATA),
    .be_o    (be),
    .wdata_o (wdata),
    .ldata_o (ldata)
  );

  // Access FSM: request issue, ACK wait with timeout, and parking read data while writeback is stalled.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    req     = 1'b0;
    stall   = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_ok) begin
          req = 1'b1;
          if (DMEM_ACK) begin
            if (WB_STALL) begin
              state_d = ST_HOLD;
              hold_d  = ldata;
            end
          end else begin
            stall   = 1'b1;
            state_d = ST_ACCESS;
            cnt_d   = CW'(1);
          end
        end
      end
      ST_ACCESS: begin
        if (cnt_q >= CW'(TIMEOUT)) begin
          // Request is dropped and the access completes with a fault; the
          // counter stays saturated until writeback can take the result.
          tmo = 1'b1;
          if (!WB_STALL) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end else begin
          req = 1'b1;
          if (DMEM_ACK) begin
            cnt_d = '0;
            if (WB_STALL) begin
              state_d = ST_HOLD;
              hold_d  = ldata;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            stall = 1'b1;
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_HOLD: begin
        // HOLD releases the stage in the same cycle writeback opens up, so the
        // parked result retires without re-requesting memory.
        stall = WB_STALL;
        if (!WB_STALL) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM, timeout counter and hold buffer registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

  // Branch/jump resolution for the redirect mux.
  always_comb begin
    pc_mux = 1'b0;
    if (MEM_V) begin
      if (opcode == OPC_JAL || opcode == OPC_JALR) begin
        pc_mux = 1'b1;
      end else if (opcode == OPC_BRANCH) begin
        case (f3)
          F3_BEQ:  pc_mux = (MEM_SR1 == MEM_SR2);
          F3_BNE:  pc_mux = (MEM_SR1 != MEM_SR2);
          F3_BLT:  pc_mux = ($signed(MEM_SR1) <  $signed(MEM_SR2));
          F3_BGE:  pc_mux = ($signed(MEM_SR1) >= $signed(MEM_SR2));
          F3_BLTU: pc_mux = (MEM_SR1 <  MEM_SR2);
          F3_BGEU: pc_mux = (MEM_SR1 >= MEM_SR2);
          default: pc_mux = 1'b0;
        endcase
      end
    end
  end

  // Load result selection: parked data after HOLD, live lane otherwise, zero on timeout.
  always_comb begin
    mem_res = '0;
    if (is_load && !tmo) mem_res = (state_q == ST_HOLD) ? hold_q : ldata;
  end

  assign adv = !WB_STALL && !stall;

  // Writeback pipeline registers advance only when neither side is stalled.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wb_v_q      <= 1'b0;
      wb_ir_q     <= '0;
      wb_npc_q    <= '0;
      wb_alu_q    <= '0;
      wb_mem_q    <= '0;
      wb_pc_mux_q <= 1'b0;
    end else if (adv) begin
      wb_v_q      <= MEM_V;
      wb_ir_q     <= MEM_IR;
      wb_npc_q    <= MEM_NPC;
      wb_alu_q    <= MEM_ALU_RESULT;
      wb_mem_q    <= mem_res;
      wb_pc_mux_q <= pc_mux;
    end
  end

  // Fault flags travel with the instruction; an empty slot clears them even while stalled.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      lam_q <= 1'b0;
      sam_q <= 1'b0;
      laf_q <= 1'b0;
      saf_q <= 1'b0;
    end else if (adv || !MEM_V) begin
      lam_q <= is_load  && misal;
      sam_q <= is_store && misal;
      laf_q <= is_load  && (bad_size || tmo);
      saf_q <= is_store && (bad_size || tmo);
    end
  end

  // A reset in the middle of an access must not leave the request asserted.
  assign DMEM_REQ   = req && !RESET;
  assign DMEM_WE    = DMEM_REQ && is_store;
  assign DMEM_ADDR  = {MEM_ALU_RESULT[XLEN-1:OW], {OW{1'b0}}};
  assign DMEM_BE    = DMEM_REQ ? be : '0;
  assign DMEM_WDATA = DMEM_REQ ? wdata : '0;
  assign MEM_STALL  = stall;

  assign WB_V          = wb_v_q;
  assign WB_IR         = wb_ir_q;
  assign WB_NPC        = wb_npc_q;
  assign WB_ALU_RESULT = wb_alu_q;
  assign WB_MEM_RESULT = wb_mem_q;
  assign WB_PC_MUX     = wb_pc_mux_q;
  assign MEM_LAM       = lam_q;
  assign MEM_SAM       = sam_q;
  assign MEM_LAF       = laf_q;
  assign MEM_SAF       = saf_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu (XLEN=64, TIMEOUT=4).
// Single-cycle vectors from a table, then hand-written multi-cycle sequences.
// Inputs change 1ns after the rising edge; combinational outputs sampled at the falling edge.
module tb_mem_lsu;

  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] JL = 7'b1101111;
  localparam logic [6:0] JR = 7'b1100111;
  localparam logic [6:0] AL = 7'b0110011;

  logic        CLK = 1'b0;
  logic        RESET, WB_STALL, MEM_V, DMEM_ACK;
  logic [31:0] MEM_IR;
  logic [63:0] MEM_ALU_RESULT, MEM_SR1, MEM_SR2, MEM_NPC, DMEM_RDATA;
  logic        DMEM_REQ, DMEM_WE, WB_V, WB_PC_MUX;
  logic        MEM_LAM, MEM_SAM, MEM_LAF, MEM_SAF, MEM_STALL;
  logic [63:0] DMEM_ADDR, DMEM_WDATA, WB_NPC, WB_ALU_RESULT, WB_MEM_RESULT;
  logic [7:0]  DMEM_BE;
  logic [31:0] WB_IR;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  mem_lsu #(.XLEN(64), .TIMEOUT(4)) dut (
    .CLK(CLK), .RESET(RESET), .WB_STALL(WB_STALL), .MEM_V(MEM_V), .MEM_IR(MEM_IR),
    .MEM_ALU_RESULT(MEM_ALU_RESULT), .MEM_SR1(MEM_SR1), .MEM_SR2(MEM_SR2), .MEM_NPC(MEM_NPC),
    .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR), .DMEM_BE(DMEM_BE),
    .DMEM_WDATA(DMEM_WDATA), .DMEM_ACK(DMEM_ACK), .DMEM_RDATA(DMEM_RDATA),
    .WB_V(WB_V), .WB_IR(WB_IR), .WB_NPC(WB_NPC), .WB_ALU_RESULT(WB_ALU_RESULT),
    .WB_MEM_RESULT(WB_MEM_RESULT), .WB_PC_MUX(WB_PC_MUX),
    .MEM_LAM(MEM_LAM), .MEM_SAM(MEM_SAM), .MEM_LAF(MEM_LAF), .MEM_SAF(MEM_SAF),
    .MEM_STALL(MEM_STALL)
  );

  typedef struct {
    logic        v;
    logic [31:0] ir;
    logic [63:0] alu;
    logic [63:0] sr1;
    logic [63:0] sr2;
    logic [63:0] rdata;
    logic        ack;
    logic        x_req;
    logic [7:0]  x_be;
    logic [63:0] x_wdata;
    logic        x_wbv;
    logic        x_pcm;
    logic [63:0] x_mres;
    logic [3:0]  x_flt;   // {lam, sam, laf, saf}
  } vec_t;

  vec_t vt[$];

  function automatic logic [31:0] ins(input logic [6:0] op, input logic [2:0] f3);
    return {17'h0, f3, 5'h0, op};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ir, input logic [63:0] alu,
                       input logic [63:0] s2, input logic ack, input logic [63:0] rd,
                       input logic wbs);
    MEM_V = v; MEM_IR = ir; MEM_ALU_RESULT = alu; MEM_NPC = alu + 64'd4;
    MEM_SR2 = s2; DMEM_ACK = ack; DMEM_RDATA = rd; WB_STALL = wbs;
  endtask

  task automatic edge1();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int stall_cnt, rise_cnt;
    logic prev_req;

    RESET = 1'b1; WB_STALL = 1'b0; MEM_V = 1'b0; DMEM_ACK = 1'b0; MEM_IR = '0;
    MEM_ALU_RESULT = '0; MEM_SR1 = '0; MEM_SR2 = '0; MEM_NPC = '0; DMEM_RDATA = '0;
    edge1(); edge1();

    // Reset state
    chk("rst_wbv", WB_V, 0);
    chk("rst_pcm", WB_PC_MUX, 0);
    chk("rst_flags", {MEM_LAM, MEM_SAM, MEM_LAF, MEM_SAF}, 0);
    chk("rst_mres", WB_MEM_RESULT, 0);
    chk("rst_alu", WB_ALU_RESULT, 0);
    chk("rst_req", DMEM_REQ, 0);
    RESET = 1'b0;

    //            v  ir             alu       sr1      sr2                     rdata                    ack req be     wdata                   wbv pcm mres                    flt
    vt.push_back('{1, ins(LD,3'd1), 64'h1006, 64'd0,  64'd0,                  64'h8001_0000_0000_0000, 1, 1, 8'hC0, 64'd0,                  1, 0, 64'hFFFF_FFFF_FFFF_8001, 4'b0000});
    vt.push_back('{1, ins(LD,3'd5), 64'h1006, 64'd0,  64'd0,                  64'h8001_0000_0000_0000, 1, 1, 8'hC0, 64'd0,                  1, 0, 64'h0000_0000_0000_8001, 4'b0000});
    vt.push_back('{1, ins(LD,3'd0), 64'h1003, 64'd0,  64'd0,                  64'h0000_0000_8500_0000, 1, 1, 8'h08, 64'd0,                  1, 0, 64'hFFFF_FFFF_FFFF_FF85, 4'b0000});
    vt.push_back('{1, ins(LD,3'd4), 64'h1003, 64'd0,  64'd0,                  64'h0000_0000_8500_0000, 1, 1, 8'h08, 64'd0,                  1, 0, 64'h0000_0000_0000_0085, 4'b0000});
    vt.push_back('{1, ins(LD,3'd2), 64'h1004, 64'd0,  64'd0,                  64'h9ABC_DEF0_1234_5678, 1, 1, 8'hF0, 64'd0,                  1, 0, 64'hFFFF_FFFF_9ABC_DEF0, 4'b0000});
    vt.push_back('{1, ins(LD,3'd6), 64'h1004, 64'd0,  64'd0,                  64'h9ABC_DEF0_1234_5678, 1, 1, 8'hF0, 64'd0,                  1, 0, 64'h0000_0000_9ABC_DEF0, 4'b0000});
    vt.push_back('{1, ins(LD,3'd3), 64'h1008, 64'd0,  64'd0,                  64'h0123_4567_89AB_CDEF, 1, 1, 8'hFF, 64'd0,                  1, 0, 64'h0123_4567_89AB_CDEF, 4'b0000});
    vt.push_back('{1, ins(ST,3'd3), 64'h1000, 64'd0,  64'hCAFE_F00D_1234_5678, 64'd0,                  1, 1, 8'hFF, 64'hCAFE_F00D_1234_5678, 1, 0, 64'd0,                  4'b0000});
    vt.push_back('{1, ins(ST,3'd1), 64'h1006, 64'd0,  64'h0000_0000_0000_1234, 64'd0,                  1, 1, 8'hC0, 64'h1234_0000_0000_0000, 1, 0, 64'd0,                  4'b0000});
    vt.push_back('{1, ins(ST,3'd2), 64'h1002, 64'd0,  64'h5555,               64'd0,                  0, 0, 8'h00, 64'd0,                  1, 0, 64'd0,                  4'b0100});
    vt.push_back('{1, ins(LD,3'd1), 64'h1001, 64'd0,  64'd0,                  64'd0,                  0, 0, 8'h00, 64'd0,                  1, 0, 64'd0,                  4'b1000});
    vt.push_back('{1, ins(LD,3'd3), 64'h1004, 64'd0,  64'd0,                  64'd0,                  0, 0, 8'h00, 64'd0,                  1, 0, 64'd0,                  4'b1000});
    vt.push_back('{1, ins(BR,3'd4), 64'h2000, '1,     64'd1,                  64'd0,                  0, 0, 8'h00, 64'd0,                  1, 1, 64'd0,                  4'b0000});
    vt.push_back('{1, ins(BR,3'd6), 64'h2000, '1,     64'd1,                  64'd0,                  0, 0, 8'h00, 64'd0,                  1, 0, 64'd0,                  4'b0000});
    vt.push_back('{1, ins(BR,3'd5), 64'h2000, '1,     64'd1,                  64'd0,                  0, 0, 8'h00, 64'd0,                  1, 0, 64'd0,                  4'b0000});
    vt.push_back('{1, ins(BR,3'd7), 64'h2000, '1,     64'd1,                  64'd0,                  0, 0, 8'h00, 64'd0,                  1, 1, 64'd0,                  4'b0000});
    vt.push_back('{1, ins(BR,3'd0), 64'h2000, 64'd5,  64'd5,                  64'd0,                  0, 0, 8'h00, 64'd0,                  1, 1, 64'd0,                  4'b0000});
    vt.push_back('{1, ins(BR,3'd1), 64'h2000, 64'd5,  64'd5,                  64'd0,                  0, 0, 8'h00, 64'd0,                  1, 0, 64'd0,                  4'b0000});
    vt.push_back('{1, ins(BR,3'd1), 64'h2000, 64'd5,  64'd6,                  64'd0,                  0, 0, 8'h00, 64'd0,                  1, 1, 64'd0,                  4'b0000});
    vt.push_back('{1, ins(BR,3'd2), 64'h2000, 64'd5,  64'd5,                  64'd0,                  0, 0, 8'h00, 64'd0,                  1, 0, 64'd0,                  4'b0000});
    vt.push_back('{1, ins(JL,3'd0), 64'h3000, 64'd0,  64'd0,                  64'd0,                  0, 0, 8'h00, 64'd0,                  1, 1, 64'd0,                  4'b0000});
    vt.push_back('{1, ins(JR,3'd0), 64'h3004, 64'd0,  64'd0,                  64'd0,                  0, 0, 8'h00, 64'd0,                  1, 1, 64'd0,                  4'b0000});
    vt.push_back('{1, ins(AL,3'd0), 64'h4444, 64'd0,  64'd0,                  64'd0,                  0, 0, 8'h00, 64'd0,                  1, 0, 64'd0,                  4'b0000});
    vt.push_back('{0, ins(LD,3'd3), 64'h1000, 64'd0,  64'd0,                  64'd0,                  1, 0, 8'h00, 64'd0,                  0, 0, 64'd0,                  4'b0000});

    // Single-cycle vectors: every one must complete without stalling.
    foreach (vt[i]) begin
      drive(vt[i].v, vt[i].ir, vt[i].alu, vt[i].sr2, vt[i].ack, vt[i].rdata, 1'b0);
      MEM_SR1 = vt[i].sr1;
      @(negedge CLK);
      chk($sformatf("v%0d_req", i), DMEM_REQ, vt[i].x_req);
      chk($sformatf("v%0d_stall", i), MEM_STALL, 0);
      if (vt[i].x_req) begin
        chk($sformatf("v%0d_be", i), DMEM_BE, vt[i].x_be);
        chk($sformatf("v%0d_we", i), DMEM_WE, vt[i].ir[6:0] == ST);
        if (vt[i].ir[6:0] == ST) chk($sformatf("v%0d_wdata", i), DMEM_WDATA, vt[i].x_wdata);
      end
      edge1();
      chk($sformatf("v%0d_wbv", i), WB_V, vt[i].x_wbv);
      chk($sformatf("v%0d_pcm", i), WB_PC_MUX, vt[i].x_pcm);
      chk($sformatf("v%0d_flt", i), {MEM_LAM, MEM_SAM, MEM_LAF, MEM_SAF}, vt[i].x_flt);
      if (vt[i].v) begin
        chk($sformatf("v%0d_ir", i), WB_IR, vt[i].ir);
        chk($sformatf("v%0d_npc", i), WB_NPC, vt[i].alu + 64'd4);
        chk($sformatf("v%0d_alu", i), WB_ALU_RESULT, vt[i].alu);
      end
      if (vt[i].ir[6:0] == LD && vt[i].x_flt == 4'b0000 && vt[i].v)
        chk($sformatf("v%0d_mres", i), WB_MEM_RESULT, vt[i].x_mres);
    end

    // SB 0xAB at 0x1005, ACK three cycles late: request held stable while stalled.
    stall_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, ins(ST, 3'd0), 64'h1005, 64'hAB, (k == 3), 64'd0, 1'b0);
      @(negedge CLK);
      if (MEM_STALL) stall_cnt++;
      chk($sformatf("sb%0d_req", k), DMEM_REQ, 1);
      chk($sformatf("sb%0d_we", k), DMEM_WE, 1);
      chk($sformatf("sb%0d_addr", k), DMEM_ADDR, 64'h1000);
      chk($sformatf("sb%0d_be", k), DMEM_BE, 8'h20);
      chk($sformatf("sb%0d_lane", k), DMEM_WDATA[47:40], 8'hAB);
      edge1();
    end
    chk("sb_stall_cycles", stall_cnt, 3);
    chk("sb_wbv", WB_V, 1);
    chk("sb_flt", {MEM_LAM, MEM_SAM, MEM_LAF, MEM_SAF}, 0);

    // Load ACKed while writeback is stalled for two cycles: data parked, one request only.
    drive(1'b0, ins(AL, 3'd0), 64'h0, 64'd0, 1'b0, 64'd0, 1'b0);
    edge1();
    rise_cnt = 0;
    prev_req = 1'b0;
    drive(1'b1, ins(LD, 3'd3), 64'h1010, 64'd0, 1'b0, 64'd0, 1'b0);
    @(negedge CLK);
    if (DMEM_REQ && !prev_req) rise_cnt++;
    prev_req = DMEM_REQ;
    chk("hold0_req", DMEM_REQ, 1);
    chk("hold0_stall", MEM_STALL, 1);
    edge1();
    DMEM_ACK = 1'b1; DMEM_RDATA = 64'h1122_3344_5566_7788; WB_STALL = 1'b1;
    @(negedge CLK);
    if (DMEM_REQ && !prev_req) rise_cnt++;
    prev_req = DMEM_REQ;
    chk("hold1_req", DMEM_REQ, 1);
    edge1();
    chk("hold1_wbv", WB_V, 0);
    DMEM_ACK = 1'b0; DMEM_RDATA = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge CLK);
    if (DMEM_REQ && !prev_req) rise_cnt++;
    prev_req = DMEM_REQ;
    chk("hold2_req", DMEM_REQ, 0);
    chk("hold2_stall", MEM_STALL, 1);
    edge1();
    chk("hold2_wbv", WB_V, 0);
    WB_STALL = 1'b0;
    @(negedge CLK);
    if (DMEM_REQ && !prev_req) rise_cnt++;
    prev_req = DMEM_REQ;
    chk("hold3_req", DMEM_REQ, 0);
    edge1();
    chk("hold_wbv", WB_V, 1);
    chk("hold_mres", WB_MEM_RESULT, 64'h1122_3344_5566_7788);
    MEM_V = 1'b0;
    @(negedge CLK);
    if (DMEM_REQ && !prev_req) rise_cnt++;
    chk("hold_req_count", rise_cnt, 1);
    edge1();

    // No ACK at all: request for four cycles, then dropped with a load access fault.
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, ins(LD, 3'd2), 64'h1020, 64'd0, 1'b0, 64'd0, 1'b0);
      @(negedge CLK);
      chk($sformatf("to%0d_req", k), DMEM_REQ, k < 4);
      chk($sformatf("to%0d_stall", k), MEM_STALL, k < 4);
      edge1();
    end
    chk("to_laf", MEM_LAF, 1);
    chk("to_saf", MEM_SAF, 0);
    chk("to_wbv", WB_V, 1);
    MEM_V = 1'b0;
    edge1();
    chk("to_laf_clear", MEM_LAF, 0);
    chk("to_wbv_clear", WB_V, 0);

    // Reset in the middle of an access; a late ACK afterwards changes nothing.
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, ins(LD, 3'd3), 64'h1030, 64'd0, 1'b0, 64'd0, 1'b0);
      @(negedge CLK);
      chk($sformatf("mr%0d_req", k), DMEM_REQ, 1);
      edge1();
    end
    RESET = 1'b1; MEM_V = 1'b0;
    edge1();
    RESET = 1'b0; DMEM_ACK = 1'b1; DMEM_RDATA = 64'h5A5A_5A5A_5A5A_5A5A;
    chk("mr_req_after", DMEM_REQ, 0);
    @(negedge CLK);
    chk("mr_stall", MEM_STALL, 0);
    chk("mr_req_late_ack", DMEM_REQ, 0);
    edge1();
    chk("mr_wbv", WB_V, 0);
    chk("mr_flt", {MEM_LAM, MEM_SAM, MEM_LAF, MEM_SAF}, 0);
    DMEM_ACK = 1'b0;
    edge1();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
